addsub_pipe: RTL and testbench



---
 rtl/addsub_pipe.sv | 143 ++++++++++++++
 tb/tb_addsub_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined WIDTH-bit adder/subtractor, CHUNK bits resolved per stage
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand word valid
//   in_ready   block accepts the operand word this cycle
//   a, b       operands (WIDTH bits)
//   carry_in   carry into bit 0
//   sub        0 = add b, 1 = add ~b
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result bits [WIDTH-1:0]
//   carry_out  result bit WIDTH
//   overflow   signed overflow of the raw result
//   zero       final sum == 0
//
// Optional feature macro: ADDSUB_SAT_EN (signed saturation of sum on overflow).

module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_width
        $error("addsub_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

    // The whole pipeline moves as one shift register: it advances whenever
    // the output slot is empty or being drained this cycle.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed on entry to this stage.
        localparam int IW = WIDTH - k * CHUNK;
        // Operand bits carried onward. The last stage keeps only the operand
        // sign bits, which the overflow flag needs after the final register.
        localparam int RW = (k == LAST) ? 1 : IW - CHUNK;

        logic                    src_v;
        logic                    src_c;
        logic [IW-1:0]           src_a;
        logic [IW-1:0]           src_b;
        logic [CHUNK:0]          part;
        logic [(k+1)*CHUNK-1:0]  sum_next;
        logic [RW-1:0]           a_keep;
        logic [RW-1:0]           b_keep;

        logic                    v_q;
        logic                    c_q;
        logic [RW-1:0]           a_q;
        logic [RW-1:0]           b_q;
        logic [(k+1)*CHUNK-1:0]  s_q;

        if (k == 0) begin : g_src
            assign src_v    = in_valid;
            assign src_c    = carry_in;
            assign src_a    = a;
            assign src_b    = sub ? ~b : b;
            assign sum_next = part[CHUNK-1:0];
        end else begin : g_src
            assign src_v    = g_stage[k-1].v_q;
            assign src_c    = g_stage[k-1].c_q;
            assign src_a    = g_stage[k-1].a_q;
            assign src_b    = g_stage[k-1].b_q;
            // Completed low slices sit below the slice resolved here.
            assign sum_next = {part[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign part = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, src_c};

        if (k == LAST) begin : g_keep
            assign a_keep = src_a[IW-1];
            assign b_keep = src_b[IW-1];
        end else begin : g_keep
            assign a_keep = src_a[IW-1:CHUNK];
            assign b_keep = src_b[IW-1:CHUNK];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= src_v;
                c_q <= part[CHUNK];
                a_q <= a_keep;
                b_q <= b_keep;
                s_q <= sum_next;
            end
        end
    end

    logic [WIDTH-1:0] raw_sum;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;

    assign raw_sum   = g_stage[LAST].s_q;
    assign a_msb     = g_stage[LAST].a_q[0];
    assign b_msb     = g_stage[LAST].b_q[0];
    assign out_valid = g_stage[LAST].v_q;
    assign carry_out = g_stage[LAST].c_q;

    // All final-stage registers clear in reset, which makes this evaluate to 0.
    assign ovf      = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
    assign overflow = ovf;

`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of a: 0x7F..F when a is positive, 0x80..0 otherwise.
    assign sum = ovf ? {a_msb, {(WIDTH-1){!a_msb}}} : raw_sum;
`else
    assign sum = raw_sum;
`endif

    // Gated by valid so the flag reads 0 while the pipeline is empty after reset.
    assign zero = out_valid && (sum == '0);

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard testbench for addsub_pipe at 8/4 and 16/4

module tb_addsub_pipe;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       iv;
    logic [1:0]       ordy;
    logic [1:0]       isub;
    logic [1:0]       icin;
    logic [1:0][15:0] ia;
    logic [1:0][15:0] ib;
    wire  [1:0]       ir;
    wire  [1:0]       ovl;
    wire  [1:0]       co;
    wire  [1:0]       ovf;
    wire  [1:0]       zr;
    wire  [7:0]       sum8;
    wire  [15:0]      sum16;

    addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ia[0][7:0]), .b(ib[0][7:0]),
        .carry_in(icin[0]), .sub(isub[0]),
        .out_valid(ovl[0]), .out_ready(ordy[0]),
        .sum(sum8), .carry_out(co[0]), .overflow(ovf[0]), .zero(zr[0])
    );

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ia[1]), .b(ib[1]),
        .carry_in(icin[1]), .sub(isub[1]),
        .out_valid(ovl[1]), .out_ready(ordy[1]),
        .sum(sum16), .carry_out(co[1]), .overflow(ovf[1]), .zero(zr[1])
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          last_stall[2] = '{-1, -1};
    logic        stalled[2] = '{1'b0, 1'b0};
    logic [15:0] held[2];
    logic        done = 1'b0;

    function automatic int wid(input int g);
        return (g == 0) ? 8 : 16;
    endfunction

    function automatic int stg(input int g);
        return (g == 0) ? 2 : 4;
    endfunction

    function automatic logic [15:0] osum(input int g);
        return (g == 0) ? {8'h00, sum8} : sum16;
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: plain integer arithmetic, signed overflow as a range check.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic s, input logic c);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] be;
        logic [16:0] full;
        int          half;
        int          sa;
        int          sb;
        int          t;
        mask  = 16'((17'd1 << w) - 17'd1);
        be    = s ? (~bv & mask) : bv;
        full  = {1'b0, av} + {1'b0, be} + {16'd0, c};
        e.sum = full[15:0] & mask;
        e.co  = full[w];
        half  = 1 << (w - 1);
        sa    = int'(av) - ((int'(av) >= half) ? 2 * half : 0);
        sb    = int'(be) - ((int'(be) >= half) ? 2 * half : 0);
        t     = sa + sb + int'(c);
        e.ov  = (t >= half) || (t < -half);
`ifdef ADDSUB_SAT_EN
        if (e.ov) e.sum = (sa < 0) ? 16'(half) : 16'(half - 1);
`endif
        e.z = (e.sum == 16'd0);
        e.t = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [w%0d] @cycle %0d: got 0x%0h, expected 0x%0h", nm, wid(g), cyc, act, exp);
        end
    endtask

    task automatic rst_chk();
        for (int g = 0; g < 2; g++) begin
            chk("rst_out_valid", g, 32'(ovl[g]), 32'd0);
            chk("rst_sum", g, 32'(osum(g)), 32'd0);
            chk("rst_carry_out", g, 32'(co[g]), 32'd0);
            chk("rst_overflow", g, 32'(ovf[g]), 32'd0);
            chk("rst_zero", g, 32'(zr[g]), 32'd0);
            chk("rst_in_ready", g, 32'(ir[g]), 32'd1);
        end
    endtask

    task automatic mon(input int g);
        exp_t        e;
        logic [15:0] s;
        s = osum(g);
        if (iv[g] && ir[g]) begin
            e   = model(wid(g), ia[g], ib[g], isub[g], icin[g]);
            e.t = cyc;
            if (g == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (stalled[g]) begin
            chk("stall_out_valid", g, 32'(ovl[g]), 32'd1);
            chk("stall_sum_stable", g, 32'(s), 32'(held[g]));
        end
        if (ovl[g] && !ordy[g]) begin
            chk("in_ready_stalled", g, 32'(ir[g]), 32'd0);
            stalled[g]    = 1'b1;
            held[g]       = s;
            last_stall[g] = cyc;
        end else begin
            stalled[g] = 1'b0;
        end
        if (ovl[g] && ordy[g]) begin
            if (qsize(g) == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL stale_output [w%0d] @cycle %0d: got result 0x%0h, expected no output",
                         wid(g), cyc, s);
            end else begin
                e = (g == 0) ? q0.pop_front() : q1.pop_front();
                chk("sum", g, 32'(s), 32'(e.sum));
                chk("carry_out", g, 32'(co[g]), 32'(e.co));
                chk("overflow", g, 32'(ovf[g]), 32'(e.ov));
                chk("zero", g, 32'(zr[g]), 32'(e.z));
                if (e.t > last_stall[g]) chk("latency", g, 32'(cyc - e.t), 32'(stg(g)));
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            stalled[0] = 1'b0;
            stalled[1] = 1'b0;
        end else begin
            mon(0);
            mon(1);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send(input int g, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input logic c);
        logic [15:0] mask;
        mask    = (g == 0) ? 16'h00FF : 16'hFFFF;
        ia[g]   = av & mask;
        ib[g]   = bv & mask;
        isub[g] = s;
        icin[g] = c;
        iv[g]   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ir[g]) break;
            if (t == 199) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout [w%0d]: got no in_ready, expected acceptance", wid(g));
            end
        end
        @(posedge clk);
        #1;
        iv[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        ordy[g] = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (qsize(g) == 0) break;
        end
        #1;
        chk("drain_empty", g, 32'(qsize(g)), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        iv    = '0;
        ordy  = 2'b11;
        isub  = '0;
        icin  = '0;
        ia    = '0;
        ib    = '0;
        #2 rst_n = 1'b0;
        #1 rst_chk();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 16'h3C, 16'h15, 1'b0, 1'b0);
        send(0, 16'hFF, 16'h01, 1'b0, 1'b0);
        send(0, 16'h7F, 16'h01, 1'b0, 1'b0);
        send(0, 16'h10, 16'h20, 1'b1, 1'b1);
        send(0, 16'h80, 16'h01, 1'b1, 1'b1);
        send(0, 16'h00, 16'h00, 1'b0, 1'b0);
        send(0, 16'h55, 16'h55, 1'b1, 1'b1);
        send(0, 16'h80, 16'h80, 1'b0, 1'b0);
        drain(0);

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1 ordy[0] = 1'b0;
                repeat (4) @(posedge clk);
                #1 ordy[0] = 1'b1;
            end
        join
        drain(0);

        for (int i = 0; i < 6; i++)
            send(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain(0);

        send(0, 16'h11, 16'h22, 1'b0, 1'b0);
        send(0, 16'h33, 16'h44, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1 rst_chk();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 16'h12, 16'h34, 1'b0, 1'b1);
        drain(0);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 ordy[1] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
